fetch_pc_ctrl: RTL

//   Sequences the fetch stage: owns the PC register, drives the shared 32-bit PC adder (a+b),

---
 rtl/fetch_pc_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage sequencer: owns the PC, drives the shared PC adder, issues imem requests
// and hands fetched words to decode. Optional misaligned-redirect trap: FETCH_MISALIGN_CHECK_EN.
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic [31:0] add_sum,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD
`ifdef FETCH_MISALIGN_CHECK_EN
        , S_ERR
`endif
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        inst_valid_q, inst_valid_d;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misalign_q, misalign_d;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
`ifdef FETCH_MISALIGN_CHECK_EN
            misalign_q   <= misalign_d;
`endif
        end
    end

    // Next-state logic; a redirect overrides every state and discards a same-cycle ack
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
`ifdef FETCH_MISALIGN_CHECK_EN
        misalign_d   = misalign_q;
`endif
        if (redirect_valid) begin
            inst_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
            if (redirect_pc[1:0] != 2'b00) begin
                misalign_d = 1'b1;
                state_d    = S_ERR;
            end else begin
                misalign_d = 1'b0;
                pc_d       = redirect_pc & ~32'd3;
                state_d    = S_FETCH;
            end
`else
            pc_d    = redirect_pc & ~32'd3;
            state_d = S_FETCH;
`endif
        end else begin
            case (state_q)
                S_IDLE: state_d = S_FETCH;
                S_FETCH: begin
                    if (imem_ack) begin
                        inst_d       = imem_rdata;
                        inst_pc_d    = pc_q;
                        pc_d         = add_sum;
                        inst_valid_d = 1'b1;
                        state_d      = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (inst_ready) begin
                        inst_valid_d = 1'b0;
                        state_d      = S_FETCH;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Outputs
    always_comb begin
        add_a      = pc_q;
        add_b      = PC_STEP;
        imem_addr  = pc_q;
        imem_req   = (state_q == S_FETCH);
        inst_valid = inst_valid_q;
        inst       = inst_q;
        inst_pc    = inst_pc_q;
`ifdef FETCH_MISALIGN_CHECK_EN
        misalign_err = misalign_q;
`else
        misalign_err = 1'b0;
`endif
    end

endmodule
